// File: rtl/axis_gp_gearbox_bridge.sv
// Byte-granular gearbox from a FINN AXI-Stream to Galapagos packets.
// Holds at most one input word plus one output word; never mixes two packets in one GP beat.
module axis_gp_gearbox_bridge #(
    parameter int AXIS_DATA_WIDTH    = 32,
    parameter int GP_DATA_WIDTH      = 64,
    parameter int AXIS_NUM_TRANSFERS = 2,
    parameter bit USE_IN_TLAST       = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_aresetn,
    input  logic [31:0]                  i_core_TID,
    input  logic [31:0]                  i_core_TDEST,
    input  logic                         i_axis_TVALID,
    output logic                         o_axis_TREADY,
    input  logic [AXIS_DATA_WIDTH-1:0]   i_axis_TDATA,
    input  logic                         i_axis_TLAST,
    output logic                         o_gp_TVALID,
    input  logic                         i_gp_TREADY,
    output logic [GP_DATA_WIDTH-1:0]     o_gp_TDATA,
    output logic [GP_DATA_WIDTH/8-1:0]   o_gp_TKEEP,
    output logic [7:0]                   o_gp_TDEST,
    output logic [7:0]                   o_gp_TID,
    output logic                         o_gp_TLAST,
    output logic                         o_busy
);
    localparam int AXB       = AXIS_DATA_WIDTH / 8;
    localparam int GPB       = GP_DATA_WIDTH / 8;
    localparam int BUF_BYTES = AXB + GPB;
    localparam int BUFW      = BUF_BYTES * 8;
    localparam int CW        = $clog2(BUF_BYTES + 1);
    localparam int BCW       = (AXIS_NUM_TRANSFERS > 1) ? $clog2(AXIS_NUM_TRANSFERS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(AXIS_NUM_TRANSFERS - 1);

    if ((AXIS_DATA_WIDTH % 8) != 0 || AXIS_DATA_WIDTH < 8 ||
        (GP_DATA_WIDTH % 8) != 0 || GP_DATA_WIDTH < 8 ||
        AXIS_NUM_TRANSFERS < 1) begin : g_bad_params
        $error("axis_gp_gearbox_bridge: widths must be byte multiples >= 8 and AXIS_NUM_TRANSFERS >= 1");
    end

    logic [BUFW-1:0] buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BCW-1:0]  beat_q, beat_d;
    logic            last_pending_q, last_pending_d;
    logic            busy_q, busy_d;
    logic [7:0]      tdest_q, tdest_d;
    logic [7:0]      tid_q, tid_d;

    logic                     out_valid, out_last, out_fire;
    logic                     in_ready, in_fire, is_last;
    logic [CW-1:0]            take, remain;
    logic [BUFW-1:0]          shifted;
    logic [GPB-1:0]           keep;
    logic [GP_DATA_WIDTH-1:0] out_data;
    logic                     unused_id_hi;

    assign unused_id_hi = ^{i_core_TID[31:8], i_core_TDEST[31:8]};

    always_comb begin
        out_valid = (cnt_q >= CW'(GPB)) || (last_pending_q && (cnt_q != '0));
        out_last  = last_pending_q && (cnt_q <= CW'(GPB));
        take      = (cnt_q >= CW'(GPB)) ? CW'(GPB) : cnt_q;
        out_fire  = out_valid && i_gp_TREADY;
        // Ready may look through this cycle's output fire to free space early.
        in_ready  = i_aresetn && !last_pending_q &&
                    ((int'(cnt_q) - (out_fire ? int'(take) : 0) + AXB) <= BUF_BYTES);
        in_fire   = i_axis_TVALID && in_ready;
        is_last   = USE_IN_TLAST ? i_axis_TLAST : (beat_q == LAST_BEAT);

        keep     = '0;
        out_data = '0;
        for (int unsigned i = 0; i < GPB; i++) begin
            keep[i]           = i < 32'(cnt_q);
            out_data[i*8 +: 8] = keep[i] ? buf_q[i*8 +: 8] : 8'h00;
        end
    end

    always_comb begin
        shifted        = out_fire ? (buf_q >> (32'(take) * 8)) : buf_q;
        remain         = out_fire ? (cnt_q - take) : cnt_q;
        buf_d          = shifted;
        cnt_d          = remain;
        beat_d         = beat_q;
        last_pending_d = last_pending_q;
        busy_d         = busy_q;
        tdest_d        = tdest_q;
        tid_d          = tid_q;

        if (in_fire) begin
            // Bytes above cnt are always zero, so the new word is simply OR-ed in above them.
            buf_d  = shifted | (BUFW'(i_axis_TDATA) << (32'(remain) * 8));
            cnt_d  = remain + CW'(AXB);
            busy_d = 1'b1;
            if (!busy_q) begin
                tdest_d = i_core_TDEST[7:0];
                tid_d   = i_core_TID[7:0];
            end
            if (!USE_IN_TLAST) begin
                beat_d = is_last ? '0 : beat_q + 1'b1;
            end
            if (is_last) begin
                last_pending_d = 1'b1;
            end
        end

        if (out_fire && out_last) begin
            last_pending_d = 1'b0;
            busy_d         = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            buf_q          <= '0;
            cnt_q          <= '0;
            beat_q         <= '0;
            last_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            tdest_q        <= '0;
            tid_q          <= '0;
        end else begin
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            beat_q         <= beat_d;
            last_pending_q <= last_pending_d;
            busy_q         <= busy_d;
            tdest_q        <= tdest_d;
            tid_q          <= tid_d;
        end
    end

    assign o_axis_TREADY = in_ready;
    assign o_gp_TVALID   = out_valid;
    assign o_gp_TDATA    = out_data;
    assign o_gp_TKEEP    = keep;
    assign o_gp_TLAST    = out_last;
    assign o_gp_TDEST    = tdest_q;
    assign o_gp_TID      = tid_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_axis_gp_gearbox_bridge.sv
// Bench for axis_gp_gearbox_bridge: four configurations, directed tables plus random packets
// checked against a byte-list packet model.
module tb_axis_gp_gearbox_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] core_tid, core_tdest, axis_data;
    logic        axis_last;
    logic [3:0]  vld, gtr;
    logic [3:0]  o_rdy, o_vld, o_lst, o_bsy;
    logic [23:0] d0, d2;
    logic [63:0] d1;
    logic [31:0] d3;
    logic [2:0]  k0, k2;
    logic [7:0]  k1;
    logic [3:0]  k3;
    logic [3:0][7:0] dst, tid;

    // 0: 32->24 N=2   1: 32->64 N=3   2: 32->24 TLAST mode   3: 32->32 N=4
    axis_gp_gearbox_bridge #(.AXIS_DATA_WIDTH(32), .GP_DATA_WIDTH(24), .AXIS_NUM_TRANSFERS(2), .USE_IN_TLAST(1'b0)) u0 (
        .i_clk(clk), .i_aresetn(rst_n), .i_core_TID(core_tid), .i_core_TDEST(core_tdest),
        .i_axis_TVALID(vld[0]), .o_axis_TREADY(o_rdy[0]), .i_axis_TDATA(axis_data), .i_axis_TLAST(axis_last),
        .o_gp_TVALID(o_vld[0]), .i_gp_TREADY(gtr[0]), .o_gp_TDATA(d0), .o_gp_TKEEP(k0),
        .o_gp_TDEST(dst[0]), .o_gp_TID(tid[0]), .o_gp_TLAST(o_lst[0]), .o_busy(o_bsy[0]));
    axis_gp_gearbox_bridge #(.AXIS_DATA_WIDTH(32), .GP_DATA_WIDTH(64), .AXIS_NUM_TRANSFERS(3), .USE_IN_TLAST(1'b0)) u1 (
        .i_clk(clk), .i_aresetn(rst_n), .i_core_TID(core_tid), .i_core_TDEST(core_tdest),
        .i_axis_TVALID(vld[1]), .o_axis_TREADY(o_rdy[1]), .i_axis_TDATA(axis_data), .i_axis_TLAST(axis_last),
        .o_gp_TVALID(o_vld[1]), .i_gp_TREADY(gtr[1]), .o_gp_TDATA(d1), .o_gp_TKEEP(k1),
        .o_gp_TDEST(dst[1]), .o_gp_TID(tid[1]), .o_gp_TLAST(o_lst[1]), .o_busy(o_bsy[1]));
    axis_gp_gearbox_bridge #(.AXIS_DATA_WIDTH(32), .GP_DATA_WIDTH(24), .AXIS_NUM_TRANSFERS(2), .USE_IN_TLAST(1'b1)) u2 (
        .i_clk(clk), .i_aresetn(rst_n), .i_core_TID(core_tid), .i_core_TDEST(core_tdest),
        .i_axis_TVALID(vld[2]), .o_axis_TREADY(o_rdy[2]), .i_axis_TDATA(axis_data), .i_axis_TLAST(axis_last),
        .o_gp_TVALID(o_vld[2]), .i_gp_TREADY(gtr[2]), .o_gp_TDATA(d2), .o_gp_TKEEP(k2),
        .o_gp_TDEST(dst[2]), .o_gp_TID(tid[2]), .o_gp_TLAST(o_lst[2]), .o_busy(o_bsy[2]));
    axis_gp_gearbox_bridge #(.AXIS_DATA_WIDTH(32), .GP_DATA_WIDTH(32), .AXIS_NUM_TRANSFERS(4), .USE_IN_TLAST(1'b0)) u3 (
        .i_clk(clk), .i_aresetn(rst_n), .i_core_TID(core_tid), .i_core_TDEST(core_tdest),
        .i_axis_TVALID(vld[3]), .o_axis_TREADY(o_rdy[3]), .i_axis_TDATA(axis_data), .i_axis_TLAST(axis_last),
        .o_gp_TVALID(o_vld[3]), .i_gp_TREADY(gtr[3]), .o_gp_TDATA(d3), .o_gp_TKEEP(k3),
        .o_gp_TDEST(dst[3]), .o_gp_TID(tid[3]), .o_gp_TLAST(o_lst[3]), .o_busy(o_bsy[3]));

    logic [1:0]  sel;
    logic        s_valid, s_ready, s_last, s_busy;
    logic [63:0] s_data;
    logic [7:0]  s_keep, s_dest, s_tid;

    always_comb begin
        s_valid = o_vld[sel];
        s_ready = o_rdy[sel];
        s_last  = o_lst[sel];
        s_busy  = o_bsy[sel];
        s_dest  = dst[sel];
        s_tid   = tid[sel];
        s_data  = '0;
        s_keep  = '0;
        case (sel)
            2'd0: begin s_data = 64'(d0); s_keep = 8'(k0); end
            2'd1: begin s_data = d1;      s_keep = k1;     end
            2'd2: begin s_data = 64'(d2); s_keep = 8'(k2); end
            default: begin s_data = 64'(d3); s_keep = 8'(k3); end
        endcase
    end

    typedef struct { logic [31:0] data; logic last; logic [7:0] dest; logic [7:0] tid; } beat_t;
    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; logic [7:0] dest; logic [7:0] tid; } gp_t;
    typedef struct { int scen; logic [31:0] data; logic last; logic [7:0] dest; logic [7:0] tid; } vin_t;
    typedef struct { int scen; logic [63:0] data; logic [7:0] keep; logic last; logic [7:0] dest; logic [7:0] tid; } vout_t;

    beat_t stim_q[$];
    gp_t   exp_q[$];
    logic  rdy_trace[$];
    int    stall_cnt;
    int    checks = 0;
    int    errors = 0;
    vin_t  vin[9];
    vout_t vout[11];

    localparam int BUDGET = 4000;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int gpb_of(input int k);
        case (k)
            0: return 3;
            1: return 8;
            2: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic load_scen(input int s);
        beat_t b;
        gp_t   e;
        for (int i = 0; i < 9; i++) begin
            if (vin[i].scen == s) begin
                b.data = vin[i].data; b.last = vin[i].last; b.dest = vin[i].dest; b.tid = vin[i].tid;
                stim_q.push_back(b);
            end
        end
        for (int i = 0; i < 11; i++) begin
            if (vout[i].scen == s) begin
                e.data = vout[i].data; e.keep = vout[i].keep; e.last = vout[i].last;
                e.dest = vout[i].dest; e.tid = vout[i].tid;
                exp_q.push_back(e);
            end
        end
    endtask

    // Reference: concatenate the packet's bytes little-endian, then cut into GPB-byte beats.
    task automatic add_packet(input int k, input int nbeats);
        logic [7:0] bq[$];
        logic [7:0] pdst, pid;
        beat_t b;
        gp_t   e;
        int    g, len;
        pdst = 8'($urandom);
        pid  = 8'($urandom);
        for (int n = 0; n < nbeats; n++) begin
            b.data = $urandom;
            b.last = (n == nbeats - 1);
            b.dest = (n == 0) ? pdst : 8'($urandom);
            b.tid  = (n == 0) ? pid  : 8'($urandom);
            stim_q.push_back(b);
            for (int j = 0; j < 4; j++) bq.push_back(b.data[j*8 +: 8]);
        end
        g = gpb_of(k);
        for (int i = 0; i < bq.size(); i += g) begin
            e.data = '0;
            e.keep = '0;
            len = (bq.size() - i < g) ? bq.size() - i : g;
            for (int j = 0; j < len; j++) begin
                e.data[j*8 +: 8] = bq[i+j];
                e.keep[j] = 1'b1;
            end
            e.last = (i + g >= bq.size());
            e.dest = pdst;
            e.tid  = pid;
            exp_q.push_back(e);
        end
    endtask

    // rmode: 0 always ready, 1 random, 2 repeating 1-0-0-1. vmode: 1 inserts random valid gaps.
    task automatic run_dut(input int k, input int rmode, input bit vmode);
        int          cyc;
        logic        hold_v;
        logic [63:0] hd;
        logic [7:0]  hk, hdst, htid;
        logic        hl;
        gp_t         e;
        cyc = 0;
        hold_v = 1'b0;
        hd = '0; hk = '0; hl = 1'b0; hdst = '0; htid = '0;
        stall_cnt = 0;
        rdy_trace.delete();
        sel = 2'(k);
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < BUDGET) begin
            @(negedge clk);
            if (stim_q.size() > 0 && (!vmode || $urandom_range(3) != 0)) begin
                vld[k]     = 1'b1;
                axis_data  = stim_q[0].data;
                axis_last  = stim_q[0].last;
                core_tdest = {24'($urandom), stim_q[0].dest};
                core_tid   = {24'($urandom), stim_q[0].tid};
            end else begin
                vld[k]     = 1'b0;
                axis_data  = $urandom;
                axis_last  = 1'($urandom);
                core_tdest = $urandom;
                core_tid   = $urandom;
            end
            case (rmode)
                0: gtr[k] = 1'b1;
                1: gtr[k] = 1'($urandom_range(1));
                default: gtr[k] = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            #1;
            if (hold_v)
                chk(s_valid && s_data == hd && s_keep == hk && s_last == hl && s_dest == hdst && s_tid == htid,
                    "hold_stable", s_data, hd);
            rdy_trace.push_back(s_ready);
            if (vld[k] && !s_ready) stall_cnt++;
            if (vld[k] && s_ready) void'(stim_q.pop_front());
            if (s_valid && gtr[k]) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_beat", s_data, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk(s_data == e.data, "gp_data", s_data, e.data);
                    chk(s_keep == e.keep, "gp_keep", 64'(s_keep), 64'(e.keep));
                    chk(s_last == e.last, "gp_last", 64'(s_last), 64'(e.last));
                    chk(s_dest == e.dest, "gp_dest", 64'(s_dest), 64'(e.dest));
                    chk(s_tid == e.tid, "gp_tid", 64'(s_tid), 64'(e.tid));
                end
            end
            hold_v = s_valid && !gtr[k];
            hd = s_data; hk = s_keep; hl = s_last; hdst = s_dest; htid = s_tid;
            cyc++;
        end
        chk(cyc < BUDGET, "timeout", 64'(cyc), 64'(BUDGET));
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        vld[k] = 1'b0;
        gtr[k] = 1'b0;
        #1;
        chk(!s_valid && !s_busy, "idle_after", {62'b0, s_valid, s_busy}, 64'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_rdy[10];
        vin[0] = '{1, 32'hABCDEFAB, 1'b0, 8'd3, 8'd4};
        vin[1] = '{1, 32'hFFFFFFFF, 1'b1, 8'd3, 8'd4};
        vin[2] = '{2, 32'h11111111, 1'b0, 8'd5, 8'd6};
        vin[3] = '{2, 32'h22222222, 1'b0, 8'd5, 8'd6};
        vin[4] = '{2, 32'h33333333, 1'b1, 8'd5, 8'd6};
        vin[5] = '{4, 32'hAABBCCDD, 1'b1, 8'd3, 8'd4};
        vin[6] = '{4, 32'h01020304, 1'b0, 8'd9, 8'd10};
        vin[7] = '{4, 32'h05060708, 1'b0, 8'd1, 8'd2};
        vin[8] = '{4, 32'h090A0B0C, 1'b1, 8'd7, 8'd8};
        vout[0]  = '{1, 64'hCDEFAB, 8'h07, 1'b0, 8'd3, 8'd4};
        vout[1]  = '{1, 64'hFFFFAB, 8'h07, 1'b0, 8'd3, 8'd4};
        vout[2]  = '{1, 64'h00FFFF, 8'h03, 1'b1, 8'd3, 8'd4};
        vout[3]  = '{2, 64'h2222222211111111, 8'hFF, 1'b0, 8'd5, 8'd6};
        vout[4]  = '{2, 64'h0000000033333333, 8'h0F, 1'b1, 8'd5, 8'd6};
        vout[5]  = '{4, 64'hBBCCDD, 8'h07, 1'b0, 8'd3, 8'd4};
        vout[6]  = '{4, 64'h0000AA, 8'h01, 1'b1, 8'd3, 8'd4};
        vout[7]  = '{4, 64'h020304, 8'h07, 1'b0, 8'd9, 8'd10};
        vout[8]  = '{4, 64'h070801, 8'h07, 1'b0, 8'd9, 8'd10};
        vout[9]  = '{4, 64'h0C0506, 8'h07, 1'b0, 8'd9, 8'd10};
        vout[10] = '{4, 64'h090A0B, 8'h07, 1'b1, 8'd9, 8'd10};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        vld = '0;
        gtr = '0;
        axis_data = '0;
        axis_last = 1'b0;
        core_tdest = '0;
        core_tid = '0;
        sel = '0;

        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            chk(!s_valid && !s_ready && !s_busy && !s_last, "reset_flags",
                {60'b0, s_valid, s_ready, s_busy, s_last}, 64'h0);
            chk(s_data == 64'h0 && s_keep == 8'h0 && s_dest == 8'h0 && s_tid == 8'h0, "reset_fields",
                s_data | 64'(s_keep) | 64'(s_dest) | 64'(s_tid), 64'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            chk(s_ready, "ready_after_reset", 64'(s_ready), 64'h1);
        end

        load_scen(1);
        run_dut(0, 0, 1'b0);

        load_scen(1);
        run_dut(0, 2, 1'b0);
        chk(stall_cnt > 0, "s3_ready_drop", 64'(stall_cnt), 64'h1);

        // Reset in the middle of a packet, then a clean packet afterwards.
        sel = 2'd0;
        @(negedge clk);
        vld[0] = 1'b1;
        gtr[0] = 1'b0;
        axis_data = 32'hABCDEFAB;
        core_tdest = 32'd3;
        core_tid = 32'd4;
        @(negedge clk);
        vld[0] = 1'b0;
        #1;
        chk(s_busy && s_valid, "s6_busy_before", {62'b0, s_busy, s_valid}, 64'h3);
        rst_n = 1'b0;
        #1;
        chk(!s_valid && !s_ready && !s_busy, "s6_reset_outputs", {61'b0, s_valid, s_ready, s_busy}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(s_ready, "s6_ready_after", 64'(s_ready), 64'h1);
        load_scen(1);
        run_dut(0, 0, 1'b0);

        load_scen(2);
        run_dut(1, 0, 1'b0);

        load_scen(4);
        run_dut(2, 0, 1'b0);

        add_packet(3, 4);
        add_packet(3, 4);
        run_dut(3, 0, 1'b0);
        chk(rdy_trace.size() >= 10, "s5_trace_len", 64'(rdy_trace.size()), 64'd10);
        if (rdy_trace.size() >= 10)
            for (int i = 0; i < 10; i++)
                chk(rdy_trace[i] == exp_rdy[i], "s5_ready_pattern", 64'(rdy_trace[i]), 64'(exp_rdy[i]));

        for (int p = 0; p < 30; p++) add_packet(0, 2);
        run_dut(0, 1, 1'b1);
        for (int p = 0; p < 20; p++) add_packet(1, 3);
        run_dut(1, 1, 1'b1);
        for (int p = 0; p < 30; p++) add_packet(2, $urandom_range(5, 1));
        run_dut(2, 1, 1'b1);
        for (int p = 0; p < 20; p++) add_packet(3, 4);
        run_dut(3, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
